// File: rtl/seq_gen.sv
// Serial pattern transmitter: takes parallel words over valid/ready and
// shifts them out MSB-first, one bit per clock, with a programmable idle gap.
module seq_gen #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5,
    parameter int GAP_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [GAP_W-1:0]  in_gap,
    output logic              seq_out,
    output logic              seq_vld,
    output logic              busy,
    output logic              word_done,
    output logic [CNT_W-1:0]  word_cnt
);

    // Handshake: a word transfers on any rising edge where in_valid && in_ready.
    // in_ready is a function of state and counters only, never of in_valid.
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state;
    logic [DATA_W-1:0]  data_r;
    logic [LEN_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_r;
    logic [GAP_W-1:0]   gap_cnt;

    logic               last_bit;
    logic               take;
    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   len_m1;
    logic [DATA_W-1:0]  first_sh;
    logic [DATA_W-1:0]  next_sh;

    assign last_bit = (state == SEND) && (bit_cnt == '0);
    assign in_ready = (state == IDLE)
                    || (last_bit && (gap_r == '0))
                    || ((state == GAP) && (gap_cnt == GAP_W'(1)));
    assign take     = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // Out-of-range lengths (0 or wider than the data path) send the full word.
    assign eff_len  = ((in_len == '0) || (in_len > LEN_W'(DATA_W))) ? LEN_W'(DATA_W) : in_len;
    assign len_m1   = eff_len - LEN_W'(1);
    assign first_sh = in_data >> len_m1;
    assign next_sh  = data_r >> (bit_cnt - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_r    <= '0;
            bit_cnt   <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            seq_out   <= 1'b0;
            seq_vld   <= 1'b0;
            word_done <= 1'b0;
            word_cnt  <= '0;
        end else begin
            word_done <= 1'b0;
            if (last_bit && (word_cnt != '1)) begin
                word_cnt <= word_cnt + 1'b1;
            end

            if (take) begin
                state     <= SEND;
                data_r    <= in_data;
                gap_r     <= in_gap;
                bit_cnt   <= len_m1;
                seq_out   <= first_sh[0];
                seq_vld   <= 1'b1;
                word_done <= (len_m1 == '0);
            end else begin
                case (state)
                    SEND: begin
                        if (bit_cnt != '0) begin
                            bit_cnt   <= bit_cnt - LEN_W'(1);
                            seq_out   <= next_sh[0];
                            word_done <= (bit_cnt == LEN_W'(1));
                        end else if (gap_r != '0) begin
                            state   <= GAP;
                            gap_cnt <= gap_r;
                            seq_out <= 1'b0;
                            seq_vld <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            seq_out <= 1'b0;
                            seq_vld <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_W'(1)) begin
                            state <= IDLE;
                        end
                        gap_cnt <= gap_cnt - GAP_W'(1);
                        seq_out <= 1'b0;
                        seq_vld <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        seq_out <= 1'b0;
                        seq_vld <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a per-cycle queue model of the serial stream, directed
// words with literal expectations, then randomized traffic.
module tb_seq_gen;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;
    localparam int GAP_W  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [LEN_W-1:0]  in_len = '0;
    logic [GAP_W-1:0]  in_gap = '0;
    logic              in_ready, seq_out, seq_vld, busy, word_done;
    logic [CNT_W-1:0]  word_cnt;
    logic              sat_ready, sat_out, sat_vld, sat_busy, sat_done;
    logic [3:0]        sat_cnt;

    seq_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .in_gap(in_gap),
        .seq_out(seq_out), .seq_vld(seq_vld), .busy(busy),
        .word_done(word_done), .word_cnt(word_cnt)
    );

    // Narrow counter instance sharing the same stimulus, for saturation.
    seq_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_ready),
        .in_data(in_data), .in_len(in_len), .in_gap(in_gap),
        .seq_out(sat_out), .seq_vld(sat_vld), .busy(sat_busy),
        .word_done(sat_done), .word_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // One entry per future output cycle: {bit, vld, done}.
    logic [2:0]  exp_q[$];
    int          exp_cnt = 0;
    logic [2:0]  cur;
    logic [31:0] cap;
    int          cap_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic rdy;
        int   le;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
            return;
        end
        rdy = (exp_q.size() <= 1);
        if (exp_q.size() > 0) begin
            if (exp_q[0][0]) exp_cnt++;
            void'(exp_q.pop_front());
        end
        if (in_valid && rdy) begin
            le = (in_len == 0 || int'(in_len) > DATA_W) ? DATA_W : int'(in_len);
            for (int i = le - 1; i >= 0; i--) begin
                exp_q.push_back({in_data[i[3:0]], 1'b1, (i == 0)});
            end
            for (int g = 0; g < int'(in_gap); g++) begin
                exp_q.push_back(3'b000);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            cur = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
            check("seq_out",   32'(seq_out),   32'(cur[2]));
            check("seq_vld",   32'(seq_vld),   32'(cur[1]));
            check("word_done", 32'(word_done), 32'(cur[0]));
            check("in_ready",  32'(in_ready),  32'(exp_q.size() <= 1));
            check("busy",      32'(busy),      32'(exp_q.size() > 0));
            check("word_cnt",  32'(word_cnt),  (exp_cnt > 65535) ? 32'd65535 : 32'(exp_cnt));
            check("sat_out",   32'(sat_out),   32'(cur[2]));
            check("sat_cnt",   32'(sat_cnt),   (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt));
            if (seq_vld) begin
                cap = {cap[30:0], seq_out};
                cap_n++;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [4:0] l, input logic [3:0] g);
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        in_gap   = g;
        for (int t = 0; t < 100; t++) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: in_ready never seen within 100 cycles");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_cap();
        cap   = '0;
        cap_n = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_cnt",   32'(word_cnt), 0);
        check("rst_out",   32'(seq_out),  0);

        // Reset in the middle of a 16-bit word, on bit 5.
        in_valid = 1'b1; in_data = 16'hA5A5; in_len = 5'd16; in_gap = 4'd0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_vld_before", 32'(seq_vld), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out",  32'(seq_out),  0);
        check("mid_rst_vld",  32'(seq_vld),  0);
        check("mid_rst_busy", 32'(busy),     0);
        check("mid_rst_cnt",  32'(word_cnt), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 1);

        clear_cap();
        send(16'h00B9, 5'd8, 4'd0);
        idle(12);
        check("single_bits", cap, 32'h0000_00B9);
        check("single_n",    32'(cap_n), 8);
        check("single_cnt",  32'(word_cnt), 1);

        clear_cap();
        send(16'h000B, 5'd4, 4'd0);
        send(16'h0006, 5'd4, 4'd0);
        idle(12);
        check("b2b_bits", cap, 32'h0000_00B6);
        check("b2b_n",    32'(cap_n), 8);

        clear_cap();
        send(16'h0007, 5'd3, 4'd5);
        send(16'h0005, 5'd3, 4'd0);
        idle(15);
        check("gap_bits", cap, 32'h0000_003D);
        check("gap_n",    32'(cap_n), 6);

        clear_cap();
        send(16'h8001, 5'd0, 4'd0);
        idle(20);
        check("len0_bits", cap, 32'h0000_8001);
        check("len0_n",    32'(cap_n), 16);

        clear_cap();
        send(16'h0001, 5'd1, 4'd0);
        idle(4);
        check("len1_bits", cap, 32'h0000_0001);
        check("len1_n",    32'(cap_n), 1);

        clear_cap();
        send(16'hA5C3, 5'd20, 4'd2);
        idle(25);
        check("len20_bits", cap, 32'h0000_A5C3);
        check("len20_n",    32'(cap_n), 16);
        check("dir_cnt",    32'(word_cnt), 8);
        check("dir_sat",    32'(sat_cnt), 8);

        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 16'($urandom);
            in_len   = 5'($urandom_range(0, 31));
            in_gap   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            @(negedge clk);
        end
        idle(40);
        check("final_busy", 32'(busy), 0);
        check("final_sat",  32'(sat_cnt), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Serial pattern transmitter: the transmit end of the single-bit `seq_in` stream that the sequence detector `seq` consumes.
- Accepts parallel words over a valid/ready handshake.
- Shifts each word out MSB-first on one serial bit per clock.
- Inserts a programmable idle gap after each word.
- Drives the detector directly in integration benches and in on-chip self-test paths.

Parameters:
DATA_W, 16, maximum word length in bits (2..32)
LEN_W, 5, width of the length field; must satisfy 2^LEN_W > DATA_W
GAP_W, 4, width of the inter-word gap field
CNT_W, 16, width of the transmitted-word counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  word request
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  word to send, right-aligned (bit len-1 sent first)
in_len  input  LEN_W  bits to send; 0 or >DATA_W treated as DATA_W
in_gap  input  GAP_W  idle cycles (seq_out=0) after the word's last bit
seq_out  output  1  serial bit stream, registered
seq_vld  output  1  high while seq_out carries a data bit
busy  output  1  high in SEND or GAP
word_done  output  1  one-cycle pulse coincident with the last data bit of a word
word_cnt  output  CNT_W  words completed since reset, saturating

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, seq_out=0, seq_vld=0, busy=0, word_done=0, word_cnt=0, in_ready=1; all shift/length/gap registers cleared. Reset mid-word aborts that word; no partial count.
- Handshake: a transfer occurs on any rising edge with in_valid && in_ready. in_data, in_len and in_gap are captured only on a transfer. in_valid may drop without a transfer; nothing is captured.
- States:
  - IDLE:
    - in_ready=1, seq_out=0, seq_vld=0.
    - On a transfer go to SEND; the first bit (in_data[len-1]) appears on seq_out in the cycle after the transfer edge. Latency is 1 clock.
  - SEND:
    - One bit per cycle, MSB of the effective length first. seq_vld=1.
    - Bit counter loads len-1 and decrements.
    - The last-bit cycle is the one where the counter is 0; word_done=1 in that cycle.
    - After the last bit: go to GAP if gap>0. If gap=0, go to SEND when a transfer occurs on that edge, otherwise to IDLE.
  - GAP:
    - seq_out=0, seq_vld=0 for exactly gap cycles; gap counter loads gap and decrements.
    - Exit on the gap cycle where the counter is 1: to SEND when a transfer occurs on that edge, otherwise to IDLE.
- in_ready is combinational from state/counters:
  - 1 in IDLE.
  - 1 in the SEND last-bit cycle when the captured gap=0.
  - 1 in the final GAP cycle.
  - 0 otherwise.
  - This allows zero-bubble back-to-back words; in_ready never depends on in_valid.
- Length: effective len = (in_len==0 || in_len>DATA_W) ? DATA_W : in_len. len=1 is legal: a single SEND cycle that is also the last-bit cycle.
- word_cnt: increments on each word_done cycle; holds at 2^CNT_W-1.
- busy = (state != IDLE).
- Idle line level is 0. seq_out never glitches: it is driven from a flop.

Test Plan:
- Reset mid-word: reset asserted while a 16-bit word is on bit 5 -> seq_out, seq_vld, busy drop to 0 immediately (asynchronously, without waiting for a clock edge); word_cnt stays 0; after release in_ready=1 and the next word sends cleanly.
- Single word: in_data=16'h00B9, len=8, gap=0 after reset -> seq_out over 8 cycles = 1,0,1,1,1,0,0,1 starting 1 clk after the transfer; seq_vld high exactly 8 cycles; word_done on the 8th; word_cnt=1; then IDLE.
- Back-to-back with gap=0: two words 4'b1011 (len=4) then 4'b0110, in_valid held -> 8 consecutive seq_vld cycles, stream 1,0,1,1,0,1,1,0 with no bubble; in_ready high only in cycles 4 and 8.
- Gap insertion: len=3, data=3'b111, gap=5, second word queued -> 3 ones, exactly 5 zeros with seq_vld=0, then the second word; the transfer occurs on the 5th gap cycle.
- Length edge cases:
  - len=0 with DATA_W=16 and data=16'h8001 -> 16 bits: 1, fourteen 0s, 1.
  - len=1, data=1 -> a single 1 with word_done in the same cycle.
  - len=20 -> treated as 16.
- Detector loopback: seq_out wired to the detector's seq_in; send the directed stream 0011100110110111 as a single 16-bit word -> the detector's detection count matches the golden model.
- Counter saturation: CNT_W=4, 20 words -> word_cnt reaches 15 and holds.
